// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise, filter, deserialise frames and strip E0/F0 prefixes.
// Optional `PS2_PARITY_CHECK_EN enables odd-parity checking of each frame.
module ps2_scancode_rx #(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] scancode_o,
  output logic       code_valid_o,
  output logic       ext_o,
  output logic       frame_err_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]          clk_sync_q, data_sync_q;
  logic [FILT_LEN-1:0] filt_q;
  logic                filt_lvl_q;
  logic [TmoW-1:0]     tmo_cnt_q;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        pend_brk_q, pend_ext_q;
  logic [7:0]  scancode_q;
  logic        ext_q, code_valid_q, frame_err_q;

  logic fall, data_s, tmo_hit, par_ok, frame_ok;

  assign data_s  = data_sync_q[1];
  assign fall    = filt_lvl_q & ~|filt_q;
  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYC));

  // Synchronisers, edge filter and inactivity timer; all reset to the idle-bus level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= '1;
      filt_lvl_q  <= 1'b1;
      tmo_cnt_q   <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= {filt_q[FILT_LEN-2:0], clk_sync_q[1]};
      if (&filt_q) begin
        filt_lvl_q <= 1'b1;
      end else if (~|filt_q) begin
        filt_lvl_q <= 1'b0;
      end
      if (fall) begin
        tmo_cnt_q <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
    end else if (fall && state_q == StParity) begin
      par_q <= data_s;
    end
  end
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // In StStop the synchronised data line carries the stop bit.
  assign frame_ok = data_s & par_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      pend_brk_q   <= 1'b0;
      pend_ext_q   <= 1'b0;
      scancode_q   <= 8'h00;
      ext_q        <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        unique case (state_q)
          StIdle: begin
            if (!data_s) begin
              state_q   <= StData;
              bit_cnt_q <= 3'd0;
            end
          end
          StData: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            state_q <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (!frame_ok) begin
              frame_err_q <= 1'b1;
              pend_brk_q  <= 1'b0;
              pend_ext_q  <= 1'b0;
            end else if (shift_q == 8'hF0) begin
              pend_brk_q <= 1'b1;
            end else if (shift_q == 8'hE0) begin
              pend_ext_q <= 1'b1;
            end else begin
              // Break codes are swallowed: only make codes reach the decoder.
              if (!pend_brk_q) begin
                scancode_q   <= shift_q;
                ext_q        <= pend_ext_q;
                code_valid_q <= 1'b1;
              end
              pend_brk_q <= 1'b0;
              pend_ext_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (tmo_hit && state_q != StIdle) begin
        state_q     <= StIdle;
        frame_err_q <= 1'b1;
        pend_brk_q  <= 1'b0;
        pend_ext_q  <= 1'b0;
      end
    end
  end

  assign scancode_o   = scancode_q;
  assign ext_o        = ext_q;
  assign code_valid_o = code_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: frame table, scoreboard of expected pulses,
// plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_scancode_rx;

  localparam int unsigned FiltLen = 8;
  localparam int unsigned TmoCyc  = 1000;
  localparam int unsigned Half    = 20;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ps2_clk_i, ps2_data_i;
  logic [7:0] scancode_o;
  logic       code_valid_o, ext_o, frame_err_o;

  ps2_scancode_rx #(
    .FILT_LEN    (FiltLen),
    .TIMEOUT_CYC (TmoCyc)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .scancode_o   (scancode_o),
    .code_valid_o (code_valid_o),
    .ext_o        (ext_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       ext;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_code;
    logic       exp_ext;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (code_valid_o && frame_err_o) check("valid_and_err_together", 1, 0);
      if (code_valid_o || frame_err_o) begin
        check("pulse_width_one", {31'd0, prev_pulse}, 0);
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, code_valid_o, frame_err_o}, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pulse_kind_err", {31'd0, frame_err_o}, {31'd0, e.is_err});
          if (!e.is_err) begin
            check("sb_scancode", {24'd0, scancode_o}, {24'd0, e.code});
            check("sb_ext", {31'd0, ext_o}, {31'd0, e.ext});
          end
        end
      end
      prev_pulse = code_valid_o | frame_err_o;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data_i = b;
    wait_cyc(Half);
    ps2_clk_i = 1'b0;
    wait_cyc(Half);
    ps2_clk_i = 1'b1;
  endtask

  // Full frame; lat returns cycles from the raw stop-bit fall to the first output pulse.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            output int lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    ps2_data_i = ~bad_stop;
    wait_cyc(Half);
    ps2_clk_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= int'(Half); i++) begin
      @(posedge clk_i);
      #1;
      if (lat == 0 && (code_valid_o || frame_err_o)) lat = i;
    end
    ps2_clk_i = 1'b1;
    wait_cyc(Half);
  endtask

  task automatic push(input logic is_err, input logic [7:0] code, input logic ext);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.ext    = ext;
    sb_q.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t       vecs[14];
  int         lat;
  logic [7:0] hold11;
  logic       v11, e11;

  initial begin
`ifdef PS2_PARITY_CHECK_EN
    hold11 = 8'h72; v11 = 1'b0; e11 = 1'b1;
`else
    hold11 = 8'h5A; v11 = 1'b1; e11 = 1'b0;
`endif
    //          data   bpar  bstop valid err   code   ext
    vecs[0]  = '{8'h69, 1'b0, 1'b0, 1'b1, 1'b0, 8'h69, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h69, 1'b0};
    vecs[2]  = '{8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 8'h69, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h69, 1'b0};
    vecs[4]  = '{8'h4A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4A, 1'b1};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4A, 1'b1};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4A, 1'b1};
    vecs[7]  = '{8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h4A, 1'b1};
    vecs[8]  = '{8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 1'b0};
    vecs[9]  = '{8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 1'b0};
    vecs[10] = '{8'h5A, 1'b1, 1'b0, v11,  e11,  hold11, 1'b0};
    vecs[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, hold11, 1'b0};
    vecs[12] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, hold11, 1'b0};
    vecs[13] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0};

    rst_i      = 1'b1;
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;
    wait_cyc(3);
    check("rst_scancode", {24'd0, scancode_o}, 0);
    check("rst_ext", {31'd0, ext_o}, 0);
    check("rst_valid", {31'd0, code_valid_o}, 0);
    check("rst_err", {31'd0, frame_err_o}, 0);
    rst_i = 1'b0;
    wait_cyc(20);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].exp_valid || vecs[i].exp_err)
        push(vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_ext);
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, lat);
      if (vecs[i].exp_valid || vecs[i].exp_err) check("pulse_latency", lat, FiltLen + 3);
      check("held_scancode", {24'd0, scancode_o}, {24'd0, vecs[i].exp_code});
      check("held_ext", {31'd0, ext_o}, {31'd0, vecs[i].exp_ext});
      check("sb_drained", sb_q.size(), 0);
      wait_cyc(10);
    end

    // Partial frame then silence: must abort with one error, then recover.
    push(1'b1, 8'h00, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    wait_cyc(TmoCyc + 30);
    check("timeout_err_seen", sb_q.size(), 0);
    push(1'b0, 8'h70, 1'b0);
    send_frame(8'h70, 1'b0, 1'b0, lat);
    check("after_timeout_code", {24'd0, scancode_o}, 8'h70);
    check("after_timeout_sb", sb_q.size(), 0);

    // Clock glitch shorter than the filter with data low must not start a frame.
    ps2_data_i = 1'b0;
    ps2_clk_i  = 1'b0;
    wait_cyc(FiltLen - 1);
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;
    wait_cyc(30);
    push(1'b0, 8'h29, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, lat);
    check("after_glitch_code", {24'd0, scancode_o}, 8'h29);
    check("after_glitch_sb", sb_q.size(), 0);

    // E0 prefix, partial frame, then reset: prefix and frame both lost.
    send_frame(8'hE0, 1'b0, 1'b0, lat);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_i = 1'b1;
    wait_cyc(3);
    check("midrst_scancode", {24'd0, scancode_o}, 0);
    check("midrst_ext", {31'd0, ext_o}, 0);
    check("midrst_valid", {31'd0, code_valid_o}, 0);
    check("midrst_err", {31'd0, frame_err_o}, 0);
    rst_i = 1'b0;
    wait_cyc(20);
    push(1'b0, 8'h16, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0, lat);
    check("after_rst_code", {24'd0, scancode_o}, 8'h16);
    check("after_rst_ext", {31'd0, ext_o}, 0);

    wait_cyc(20);
    check("sb_empty_end", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receiver feeding the calculator's scancode decoder. Samples the raw keyboard clock/data lines, deserialises 11-bit device-to-host frames, strips break (F0) and extended (E0) prefixes, and presents each key-press scancode on a held 8-bit bus with a one-cycle valid strobe. Releases are consumed internally, so the decoder only ever sees make codes.

## Interface
- `FILT_LEN`, 8: consecutive identical samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYC`, 50000: system cycles without a filtered falling edge before a partial frame is aborted (1 ms at 50 MHz).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw keyboard clock, asynchronous.
- `ps2_data` input 1: raw keyboard data, asynchronous.
- `scancode` output 8: last accepted make code, held until the next one.
- `code_valid` output 1: one-cycle pulse when `scancode`/`ext` update.
- `ext` output 1: the current `scancode` was preceded by E0.
- `frame_err` output 1: one-cycle pulse on a bad stop bit, bad parity (when enabled) or timeout.

## Operation
- Both inputs pass through 2-flop synchronisers. Synchronised `ps2_clk` then feeds a `FILT_LEN`-deep shift filter. The filtered level changes only when all samples agree. A filtered 1→0 transition produces a one-cycle `fall` strobe.
- Data is sampled from synchronised `ps2_data` on the `fall` cycle.
- Frame FSM states:
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. With data=1, stay in IDLE silently.
  - DATA: shift in LSB first on each `fall`. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE. If stop=1 (and parity OK when checked), the byte is accepted. Otherwise pulse `frame_err`, discard the byte, and clear both prefix flags.
- Prefix handling on an accepted byte:
  - 8'hF0: set `pend_brk`.
  - 8'hE0: set `pend_ext`.
  - Any other byte with `pend_brk`=1: no output; clear both flags.
  - Any other byte with `pend_brk`=0: `scancode`←byte, `ext`←`pend_ext`, pulse `code_valid`, clear both flags.
  - A repeated E0 or F0 just re-sets its flag (idempotent).
- Timeout: a counter clears on every `fall` and increments otherwise, saturating. If the counter reaches `TIMEOUT_CYC` in any state other than IDLE, return to IDLE, pulse `frame_err`, and clear both prefix flags. The timeout has no effect in IDLE.
- Typematic repeats (the same make code again) produce a fresh `code_valid` each time.

## Timing
- Reset values: `scancode`=8'h00, `code_valid`=0, `ext`=0, `frame_err`=0, FSM=IDLE, flags=0, filter and synchronisers all 1s (idle bus).
- Edge latency: 2 sync cycles + `FILT_LEN` cycles from the raw `ps2_clk` fall to `fall`.
- `code_valid` and `frame_err` assert on the cycle after the `fall` that samples the stop bit. Each lasts exactly one cycle. They never assert together.
- `scancode` and `ext` change on the same edge that `code_valid` rises, then hold.
- Reset asserted mid-frame: the partial frame is lost with no pulse. After release, reception resumes at the next start bit.
- Keyboard clock ≈10–16.7 kHz, so `clk` must be at least 2·(`FILT_LEN`+2) times faster. At 50 MHz this is met with large margin.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the frame is valid only if data bits plus the parity bit contain an odd number of 1s. Otherwise the byte is rejected as described under STOP, with a `frame_err` pulse.
- Not defined: the parity bit is sampled and ignored, and only the start and stop bits are checked.

## Test plan
- Frame 0x69 (data 1001_0110 LSB first, parity 1, stop 1) → `scancode`=8'h69, `ext`=0, one `code_valid` pulse one cycle after the stop fall.
- Sequence 0x69, F0, 0x69 → exactly one `code_valid`; `scancode` stays 8'h69 after the release.
- Sequence E0, 4A → `scancode`=8'h4A, `ext`=1. A following E0, F0, 4A produces no `code_valid`; a following plain 0x72 gives `ext`=0.
- Frame 0x5A with parity forced to 0 → with `PS2_PARITY_CHECK_EN`: `frame_err` pulse, `scancode` unchanged. Without it: `scancode`=8'h5A and `code_valid`.
- Send 5 bits of a frame, then idle for `TIMEOUT_CYC`+1 cycles → `frame_err` pulse, FSM back in IDLE; a following 0x70 frame is received correctly.
- `ps2_clk` glitch low for `FILT_LEN`−1 cycles in IDLE → no state change. Assert `rst` mid-frame → all outputs 0, no pulses.
